// File: rtl/tt_vec_mul_pipe_if.sv
// ---------------------------------------------------------------------------
// tt_vec_mul_pipe_if
// Request/response bundle of the packed-element vector multiplier.
//   Request side : i_valid_0a / o_ready_0a handshake, operands i_src1_0a and
//                  i_src2_0a, element width i_sew_0a, operand signedness
//                  i_issgn_0a / i_issgnsrc2_0a, high-half select i_hi_0a,
//                  sideband i_tag_0a, pipeline kill i_flush.
//   Result side  : o_valid / i_ready handshake, o_result, o_tag.
// Modports: slave = the multiplier, master = the block issuing operations.
// ---------------------------------------------------------------------------
interface tt_vec_mul_pipe_if #(
    parameter int VLEN = 256,
    parameter int TAGW = 4
) ();
    logic            i_valid_0a;
    logic            o_ready_0a;
    logic [VLEN-1:0] i_src1_0a;
    logic [VLEN-1:0] i_src2_0a;
    logic [1:0]      i_sew_0a;
    logic            i_issgn_0a;
    logic            i_issgnsrc2_0a;
    logic            i_hi_0a;
    logic [TAGW-1:0] i_tag_0a;
    logic            i_flush;
    logic            o_valid;
    logic            i_ready;
    logic [VLEN-1:0] o_result;
    logic [TAGW-1:0] o_tag;

    modport slave (
        input  i_valid_0a, i_src1_0a, i_src2_0a, i_sew_0a, i_issgn_0a,
               i_issgnsrc2_0a, i_hi_0a, i_tag_0a, i_flush, i_ready,
        output o_ready_0a, o_valid, o_result, o_tag
    );

    modport master (
        output i_valid_0a, i_src1_0a, i_src2_0a, i_sew_0a, i_issgn_0a,
               i_issgnsrc2_0a, i_hi_0a, i_tag_0a, i_flush, i_ready,
        input  o_ready_0a, o_valid, o_result, o_tag
    );
endinterface

// File: rtl/tt_vec_mul_pipe.sv
// ---------------------------------------------------------------------------
// tt_vec_mul_pipe
// Pipelined packed-element vector multiplier. Every SEW-wide element pair
// (SEW = 8/16/32/64) is multiplied to its full 2*SEW product with each
// operand independently sign- or zero-extended; the low or high SEW bits of
// each product form the result. Latency is STAGES cycles, one operation per
// cycle, in order. A full result stall (o_valid && !i_ready) freezes the
// whole pipeline; i_flush drops everything in flight including a same-cycle
// request.
// Ports:
//   i_clk   - clock, rising edge
//   i_reset - asynchronous active-high reset of the stage valid bits
//   bus     - tt_vec_mul_pipe_if.slave (request, result, flush)
// ---------------------------------------------------------------------------
module tt_vec_mul_pipe #(
    parameter int VLEN   = 256,
    parameter int STAGES = 2,
    parameter int TAGW   = 4
) (
    input  logic            i_clk,
    input  logic            i_reset,
    tt_vec_mul_pipe_if.slave bus
);

    localparam int PW = 2 * VLEN;

    logic              stall;
    logic              advance;
    logic [STAGES-1:0] vld_p;
    logic [PW-1:0]     prod_p [STAGES];
    logic [1:0]        sew_p  [STAGES];
    logic              hi_p   [STAGES];
    logic [TAGW-1:0]   tag_p  [STAGES];

    logic [PW-1:0]     prod_sew [4];
    logic [PW-1:0]     prod_0a;
    logic [VLEN-1:0]   res_sew  [4];

    assign stall          = vld_p[STAGES-1] && !bus.i_ready;
    assign advance        = !stall;
    assign bus.o_ready_0a = advance;
    assign bus.o_valid    = vld_p[STAGES-1];

    // Issue: full double-width products for every element width. The
    // operands are extended to 2*SEW bits so the modular product is already
    // the exact signed/unsigned/mixed result.
    for (genvar s = 0; s < 4; s++) begin : g_sew
        localparam int EW = 8 << s;
        logic [PW-1:0] prod_v;
        for (genvar k = 0; k < VLEN / EW; k++) begin : g_el
            logic signed [2*EW-1:0] ax;
            logic signed [2*EW-1:0] bx;
            logic signed [2*EW-1:0] px;
            assign ax = {{EW{bus.i_issgn_0a && bus.i_src1_0a[k*EW+EW-1]}},
                         bus.i_src1_0a[k*EW +: EW]};
            assign bx = {{EW{bus.i_issgnsrc2_0a && bus.i_src2_0a[k*EW+EW-1]}},
                         bus.i_src2_0a[k*EW +: EW]};
            assign px = ax * bx;
            assign prod_v[k*2*EW +: 2*EW] = px;
        end
        assign prod_sew[s] = prod_v;
    end

    assign prod_0a = prod_sew[bus.i_sew_0a];

    // Stage valid bits: flush beats stall, which beats advance.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            vld_p <= '0;
        end else if (bus.i_flush) begin
            vld_p <= '0;
        end else if (advance) begin
            vld_p[0] <= bus.i_valid_0a;
            for (int i = 1; i < STAGES; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    // Stage data: only stages receiving a live operation load; bubbles and
    // flushed requests leave the registers untouched.
    always_ff @(posedge i_clk) begin
        if (advance && !bus.i_flush) begin
            if (bus.i_valid_0a) begin
                prod_p[0] <= prod_0a;
                sew_p[0]  <= bus.i_sew_0a;
                hi_p[0]   <= bus.i_hi_0a;
                tag_p[0]  <= bus.i_tag_0a;
            end
            for (int i = 1; i < STAGES; i++) begin
                if (vld_p[i-1]) begin
                    prod_p[i] <= prod_p[i-1];
                    sew_p[i]  <= sew_p[i-1];
                    hi_p[i]   <= hi_p[i-1];
                    tag_p[i]  <= tag_p[i-1];
                end
            end
        end
    end

    // Output: pick the low or high half of each product using the width and
    // half captured with this operation, so mixed sequences stay independent.
    for (genvar s = 0; s < 4; s++) begin : g_out
        localparam int EW = 8 << s;
        for (genvar k = 0; k < VLEN / EW; k++) begin : g_el
            assign res_sew[s][k*EW +: EW] = hi_p[STAGES-1]
                ? prod_p[STAGES-1][k*2*EW+EW +: EW]
                : prod_p[STAGES-1][k*2*EW +: EW];
        end
    end

    assign bus.o_result = res_sew[sew_p[STAGES-1]];
    assign bus.o_tag    = tag_p[STAGES-1];

endmodule

// File: tb/tb_tt_vec_mul_pipe.sv
// ---------------------------------------------------------------------------
// tb_tt_vec_mul_pipe
// Self-checking bench for tt_vec_mul_pipe: directed corner cases followed by
// randomized traffic with random back-pressure and flushes, checked against
// an element-wise arithmetic reference model and an in-order scoreboard that
// also predicts o_valid / o_ready_0a every cycle.
// ---------------------------------------------------------------------------
module tb_tt_vec_mul_pipe;

    localparam int VLEN   = 256;
    localparam int STAGES = 2;
    localparam int TAGW   = 4;

    typedef struct {
        logic [VLEN-1:0] res;
        logic [TAGW-1:0] tag;
        int              acc;
        int              stl;
    } exp_t;

    logic i_clk   = 1'b0;
    logic i_reset = 1'b1;
    int   cyc       = 0;
    int   stall_cnt = 0;
    int   pops      = 0;
    int   n_checks  = 0;
    int   n_fail    = 0;
    exp_t q[$];

    tt_vec_mul_pipe_if #(.VLEN(VLEN), .TAGW(TAGW)) bus ();

    tt_vec_mul_pipe #(.VLEN(VLEN), .STAGES(STAGES), .TAGW(TAGW)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    initial forever #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [VLEN-1:0] got,
                       input logic [VLEN-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: element-wise exact products on wide signed integers.
    function automatic logic [VLEN-1:0] ref_mul(input logic [VLEN-1:0] a,
            input logic [VLEN-1:0] b, input logic [1:0] sew,
            input logic sa, input logic sb, input logic hi);
        int              sw   = 8 << sew;
        logic [VLEN-1:0] r    = '0;
        logic [63:0]     mask = (sw == 64) ? '1 : ((64'd1 << sw) - 64'd1);
        for (int k = 0; k < VLEN / sw; k++) begin
            logic [63:0]        ea, eb;
            logic signed [129:0] av, bv, pr;
            ea = 64'(a >> (k * sw)) & mask;
            eb = 64'(b >> (k * sw)) & mask;
            av = $signed({66'd0, ea});
            bv = $signed({66'd0, eb});
            if (sa && ea[sw-1]) av = av - (130'sd1 <<< sw);
            if (sb && eb[sw-1]) bv = bv - (130'sd1 <<< sw);
            pr = av * bv;
            r  = r | (VLEN'(64'(pr >> (hi ? sw : 0)) & mask) << (k * sw));
        end
        return r;
    endfunction

    function automatic logic [VLEN-1:0] rand_vec();
        logic [VLEN-1:0] v;
        case ($urandom_range(0, 5))
            0:       v = '1;
            1:       v = '0;
            2:       v = {(VLEN/8){8'h80}};
            default: for (int i = 0; i < VLEN / 32; i++) v[i*32 +: 32] = $urandom();
        endcase
        return v;
    endfunction

    // Scoreboard / protocol monitor, sampled mid-cycle.
    always @(negedge i_clk) begin
        logic exp_v;
        if (i_reset) begin
            chk("rst_valid", VLEN'(bus.o_valid), '0);
            chk("rst_ready", VLEN'(bus.o_ready_0a), VLEN'(1'b1));
            q.delete();
        end else begin
            exp_v = (q.size() > 0) &&
                    (cyc >= q[0].acc + STAGES + (stall_cnt - q[0].stl));
            chk("o_valid", VLEN'(bus.o_valid), VLEN'(exp_v));
            chk("o_ready", VLEN'(bus.o_ready_0a), VLEN'(!(exp_v && !bus.i_ready)));
            if (exp_v && bus.o_valid) begin
                chk("result", bus.o_result, q[0].res);
                chk("tag", VLEN'(bus.o_tag), VLEN'(q[0].tag));
                if (bus.i_ready) begin
                    void'(q.pop_front());
                    pops++;
                end
            end
            if (exp_v && !bus.i_ready) stall_cnt++;
            if (bus.i_flush) begin
                q.delete();
            end else if (bus.i_valid_0a && !(exp_v && !bus.i_ready)) begin
                q.push_back('{ref_mul(bus.i_src1_0a, bus.i_src2_0a, bus.i_sew_0a,
                                      bus.i_issgn_0a, bus.i_issgnsrc2_0a, bus.i_hi_0a),
                              bus.i_tag_0a, cyc, stall_cnt});
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] sew, input logic sa, input logic sb,
                         input logic hi, input logic [VLEN-1:0] a,
                         input logic [VLEN-1:0] b, input logic [TAGW-1:0] tag);
        bus.i_valid_0a     = 1'b1;
        bus.i_sew_0a       = sew;
        bus.i_issgn_0a     = sa;
        bus.i_issgnsrc2_0a = sb;
        bus.i_hi_0a        = hi;
        bus.i_src1_0a      = a;
        bus.i_src2_0a      = b;
        bus.i_tag_0a       = tag;
    endtask

    task automatic issue_rand(input logic [TAGW-1:0] tag);
        issue(2'($urandom_range(0, 3)), 1'($urandom()), 1'($urandom()),
              1'($urandom()), rand_vec(), rand_vec(), tag);
    endtask

    // One isolated operation, result checked against a fixed value after
    // exactly STAGES cycles.
    task automatic run_single(input string name, input logic [1:0] sew,
                              input logic sa, input logic sb, input logic hi,
                              input logic [VLEN-1:0] a, input logic [VLEN-1:0] b,
                              input logic [VLEN-1:0] exp);
        issue(sew, sa, sb, hi, a, b, 4'(3));
        tick();
        bus.i_valid_0a = 1'b0;
        repeat (STAGES - 1) tick();
        @(negedge i_clk);
        chk({name, "_v"}, VLEN'(bus.o_valid), VLEN'(1'b1));
        chk(name, bus.o_result, exp);
        tick();
    endtask

    task automatic drain(input string name);
        bus.i_valid_0a = 1'b0;
        bus.i_flush    = 1'b0;
        bus.i_ready    = 1'b1;
        for (int i = 0; i < 40 && q.size() > 0; i++) tick();
        chk(name, VLEN'(q.size()), '0);
    endtask

    initial begin
        int p0;
        bus.i_valid_0a = 1'b0;
        bus.i_flush    = 1'b0;
        bus.i_ready    = 1'b1;
        issue(2'd0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        bus.i_valid_0a = 1'b0;
        i_reset = 1'b1;
        repeat (3) tick();

        // First request accepted on the first edge after reset release.
        i_reset = 1'b0;
        run_single("byte_lo", 2'd0, 1'b1, 1'b1, 1'b0, {32{8'hFF}}, {32{8'h02}}, {32{8'hFE}});
        run_single("byte_hi", 2'd0, 1'b1, 1'b1, 1'b1, {32{8'hFF}}, {32{8'h02}}, {32{8'hFF}});
        run_single("d64_hi", 2'd3, 1'b0, 1'b1, 1'b1, '1, '1, '1);
        run_single("d64_lo", 2'd3, 1'b0, 1'b1, 1'b0, '1, '1, {4{64'd1}});
        run_single("h16_mix", 2'd1, 1'b1, 1'b0, 1'b1, {16{16'h8000}}, {16{16'hFFFF}},
                   {16{16'h8000}});

        // Ten back-to-back, alternating SEW 16/32, tags 0..9.
        p0 = pops;
        for (int t = 0; t < 10; t++) begin
            issue((t % 2) ? 2'd2 : 2'd1, 1'($urandom()), 1'($urandom()),
                  1'($urandom()), rand_vec(), rand_vec(), 4'(t));
            tick();
        end
        bus.i_valid_0a = 1'b0;
        repeat (STAGES + 1) tick();
        chk("b2b_count", VLEN'(pops - p0), VLEN'(10));

        // Full-pipeline stall for several cycles.
        p0 = pops;
        bus.i_ready = 1'b0;
        for (int t = 0; t < STAGES + 3; t++) begin
            issue_rand(4'(t));
            tick();
        end
        @(negedge i_clk);
        chk("stall_ready", VLEN'(bus.o_ready_0a), '0);
        tick();
        bus.i_valid_0a = 1'b0;
        repeat (5) tick();
        drain("stall_drain");
        chk("stall_count", VLEN'(pops - p0), VLEN'(STAGES));

        // Flush with STAGES in flight plus a same-cycle request.
        for (int t = 0; t < STAGES; t++) begin
            issue_rand(4'(8 + t));
            tick();
        end
        issue_rand(4'd15);
        bus.i_ready = 1'b0;
        bus.i_flush = 1'b1;
        tick();
        bus.i_flush    = 1'b0;
        bus.i_valid_0a = 1'b0;
        bus.i_ready    = 1'b1;
        for (int i = 0; i < STAGES + 3; i++) begin
            @(negedge i_clk);
            chk("flush_quiet", VLEN'(bus.o_valid), '0);
            tick();
        end

        // Asynchronous reset between edges with work in flight.
        issue_rand(4'd1);
        tick();
        issue_rand(4'd2);
        tick();
        bus.i_valid_0a = 1'b0;
        @(posedge i_clk);
        #3;
        i_reset = 1'b1;
        #1;
        chk("areset_valid", VLEN'(bus.o_valid), '0);
        chk("areset_ready", VLEN'(bus.o_ready_0a), VLEN'(1'b1));
        @(posedge i_clk);
        #3;
        i_reset = 1'b0;
        issue_rand(4'd5);
        tick();
        bus.i_valid_0a = 1'b0;
        repeat (STAGES - 1) tick();
        @(negedge i_clk);
        chk("post_rst_v", VLEN'(bus.o_valid), VLEN'(1'b1));
        chk("post_rst_tag", VLEN'(bus.o_tag), VLEN'(5));
        tick();

        // Randomized traffic with back-pressure and occasional flushes.
        for (int i = 0; i < 400; i++) begin
            issue_rand(4'($urandom()));
            bus.i_valid_0a = ($urandom_range(0, 3) != 0);
            bus.i_ready    = ($urandom_range(0, 3) != 0);
            bus.i_flush    = ($urandom_range(0, 31) == 0);
            tick();
        end
        drain("rand_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tt_vec_mul_pipe.md
TT_VEC_MUL_PIPE -- requirements
Module: tt_vec_mul_pipe

Interface
REQ-001 Parameter VLEN, default 256: vector operand width in bits; SHALL be a multiple of 64.
REQ-002 Parameter STAGES, default 2: multiply latency in cycles; legal range 1..4.
REQ-003 Parameter TAGW, default 4: width of the sideband tag carried with each operation.
REQ-004 Ports (name, direction, width, meaning) SHALL be:
- i_clk  in  1  sole clock; all state updates on the rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_valid_0a  in  1  operation request.
- o_ready_0a  out  1  block accepts a request this cycle.
- i_src1_0a  in  VLEN  packed multiplicand elements.
- i_src2_0a  in  VLEN  packed multiplier elements.
- i_sew_0a  in  2  element width: 0=8b, 1=16b, 2=32b, 3=64b.
- i_issgn_0a  in  1  src1 is signed.
- i_issgnsrc2_0a  in  1  src2 is signed.
- i_hi_0a  in  1  return the upper SEW bits of each product (vmulh*); 0 returns the lower SEW bits (vmul).
- i_tag_0a  in  TAGW  opaque tag returned with the result.
- i_flush  in  1  kill all in-flight operations.
- o_valid  out  1  result valid.
- i_ready  in  1  consumer accepts the result.
- o_result  out  VLEN  packed SEW-wide results.
- o_tag  out  TAGW  tag of the presented result.

Function
REQ-005 Element count SHALL be VLEN/(8<<i_sew_0a); element k SHALL occupy bits [k*SEW +: SEW] of the sources and of o_result.
REQ-006 Each element product SHALL be the full 2*SEW-bit product of the sign- or zero-extended operands, per i_issgn_0a and i_issgnsrc2_0a independently (signed x unsigned supported).
REQ-007 o_result element k SHALL be product[SEW-1:0] when hi=0 and product[2*SEW-1:SEW] when hi=1.
REQ-008 A request SHALL be accepted on a cycle with i_valid_0a && o_ready_0a.
REQ-009 With no stall, an operation accepted in cycle N SHALL present o_valid=1 with its result in cycle N+STAGES.
REQ-010 The pipeline SHALL hold STAGES valid-qualified stages, each carrying sew, hi, tag and the partial or final data.
REQ-011 Stall SHALL be defined as o_valid && !i_ready.
- During a stall every stage SHALL hold its contents.
- o_result and o_tag SHALL remain stable while o_valid && !i_ready.
REQ-012 o_ready_0a SHALL equal !stall, with no combinational dependency on i_valid_0a.
REQ-013 When not stalled, the pipeline SHALL advance one stage per cycle.
- Bubbles (invalid stages) SHALL propagate; results SHALL leave in acceptance order.
REQ-014 Back-to-back accepts SHALL sustain one operation per cycle while i_ready=1.
REQ-015 i_flush SHALL clear every stage valid bit on the next edge.
- A request presented in the same cycle as i_flush SHALL be discarded.
- o_valid SHALL be 0 in the cycle after i_flush.
- The data registers need not be cleared.
REQ-016 Flush SHALL take priority over stall and accept.
REQ-017 Stage data registers SHALL load only when their incoming valid is 1 and the stage advances; no loads on bubbles (power).
REQ-018 sew and hi SHALL be captured per operation, so mixed SEW/hi sequences in flight produce independent, correct results.

Reset
REQ-019 i_reset asserted SHALL asynchronously clear all stage valid bits; o_valid=0, o_ready_0a=1.
REQ-020 Data and tag registers SHALL NOT require reset; o_result and o_tag are don't-care while o_valid=0.
REQ-021 Reset asserted mid-operation SHALL drop all in-flight operations; none SHALL emerge after deassertion.
REQ-022 The first request SHALL be accepted on the first rising edge after i_reset deasserts.

Verification
REQ-023 SEW=8, signed/signed, hi=0, every byte 0xFF x 0x02 -> after STAGES cycles, every byte 0xFE; hi=1 -> every byte 0xFF.
REQ-024 SEW=64, src1 unsigned 0xFFFF_FFFF_FFFF_FFFF, src2 signed -1, hi=1 -> upper 64 bits of -(2^64-1) = 0xFFFF_FFFF_FFFF_FFFF; hi=0 -> 0x0000_0000_0000_0001.
REQ-025 Ten back-to-back requests (tags 0..9, alternating SEW 16/32), i_ready=1 -> ten results on consecutive cycles, tags in order, each matching the reference model.
REQ-026 Hold i_ready=0 for 5 cycles with a full pipeline -> o_ready_0a=0; o_result/o_tag stable; no loss or duplication once i_ready=1.
REQ-027 i_flush with STAGES operations in flight plus a request in the same cycle -> o_valid=0 on the next cycle, and no flushed tag ever appears.
REQ-028 Assert i_reset asynchronously between clock edges with operations in flight -> o_valid falls immediately; after release, a new tag-5 request returns tag 5 after STAGES cycles.
